// File: rtl/uart_pkg.sv
// Shared types and constants for the UART debug-byte transmit path.
// FSM states, byte width and the CR/LF codes used for line-ending expansion.
package uart_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CR = 8'h0D;
  localparam logic [BYTE_W-1:0] LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_DONE,
    GAP
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, occupancy count and drop flag.
// A write into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_wr;
  logic         do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign drop  = wr_en && !do_wr;

  assign count   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + ONE;
      if (do_rd) rd_ptr <= rd_ptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers debug bytes from the slow CPU strobe and feeds the UART serializer.
// Define UART_TX_FIFO_CRLF_EN to expand each LF into a CR then LF pair.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int GAP_CLKS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BYTE_W-1:0]        wr_data,
  input  logic                     wr_valid,
  output logic                     tx_dv,
  output logic [BYTE_W-1:0]        tx_byte,
  input  logic                     tx_active,
  input  logic                     tx_done,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_full,
  output logic                     overflow
);

  localparam int GW    = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam int GLAST = (GAP_CLKS > 0) ? GAP_CLKS - 1 : 0;

  tx_state_e         state;
  tx_state_e         nxt;
  logic              s1, s2, s3;
  logic              wr_edge;
  logic              launch;
  logic              pop;
  logic              empty;
  logic              drop;
  logic              hold_head;
  logic [BYTE_W-1:0] head;
  logic [BYTE_W-1:0] load_byte;
  logic [GW-1:0]     gap_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= wr_valid;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign wr_edge = s2 && !s3;

  sync_fifo #(
    .W     (BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_edge),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (empty),
    .drop    (drop)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

`ifdef UART_TX_FIFO_CRLF_EN
  logic lf_pend;
  logic cr_first;

  // The LF stays at the head until its leading CR has gone out.
  assign cr_first  = (head == LF) && !lf_pend;
  assign load_byte = cr_first ? CR : head;
  assign hold_head = lf_pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       lf_pend <= 1'b0;
    else if (launch) lf_pend <= cr_first;
  end
`else
  assign load_byte = head;
  assign hold_head = 1'b0;
`endif

  always_comb begin
    nxt    = state;
    launch = 1'b0;
    pop    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && !tx_active) begin
          nxt    = LOAD;
          launch = 1'b1;
        end
      end
      LOAD: begin
        nxt = WAIT_DONE;
        pop = !hold_head;
      end
      WAIT_DONE: begin
        if (tx_done) nxt = (GAP_CLKS == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt == GW'(GLAST)) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx_dv   <= 1'b0;
      tx_byte <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= nxt;
      tx_dv   <= launch;
      if (launch) tx_byte <= load_byte;
      gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: transmitter model, byte scoreboard, vector table.
module tb_uart_tx_fifo;

  localparam int DEPTH    = 16;
  localparam int GAP_CLKS = 4;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    wr_data;
  logic          wr_valid;
  logic          tx_dv;
  logic [7:0]    tx_byte;
  logic          tx_active;
  logic          tx_done;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          overflow;

  logic busy = 1'b0;
  logic hold = 1'b0;
  assign tx_active = busy | hold;

  uart_tx_fifo #(
    .DEPTH    (DEPTH),
    .GAP_CLKS (GAP_CLKS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .tx_dv      (tx_dv),
    .tx_byte    (tx_byte),
    .tx_active  (tx_active),
    .tx_done    (tx_done),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int   n_tests   = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   done_cyc  = 0;
  int   pulses    = 0;
  int   frame_len = 1040;
  bit   have_done = 1'b0;
  bit   check_gap = 1'b0;
  logic prev_dv   = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    int         exp_count;
    bit         exp_full;
    bit         exp_ovf;
  } vec_t;
  vec_t vecs[17];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Transmitter: busy for frame_len clocks per launch, then a done pulse.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (tx_dv) begin
        busy = 1'b1;
        repeat (frame_len) @(negedge clk);
        busy      = 1'b0;
        tx_done   = 1'b1;
        done_cyc  = cyc;
        have_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (tx_dv) begin
      pulses++;
      check("dv_one_cycle", int'(prev_dv), 0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_launch: got byte 0x%02h expected none",
                 tx_byte);
      end else begin
        check("tx_byte", int'(tx_byte), int'(exp_q.pop_front()));
      end
      if (check_gap && have_done) begin
        n_tests++;
        if (cyc - done_cyc < GAP_CLKS + 2) begin
          n_fail++;
          $display("FAIL launch_gap: got %0d clocks required >= %0d",
                   cyc - done_cyc, GAP_CLKS + 2);
        end
      end
    end
    prev_dv = tx_dv;
  end

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    wr_data  = d;
    wr_valid = 1'b1;
    repeat (4) @(negedge clk);
    wr_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || busy || fifo_count != 0) && t < 40000) begin
      @(negedge clk);
      t++;
    end
    repeat (GAP_CLKS + 4) @(negedge clk);
    n_tests++;
    if (t >= 40000) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d queued expected 0", name,
               exp_q.size());
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int i = 0; i < 17; i++) begin
      vecs[i].data      = 8'hA0 + 8'(i);
      vecs[i].exp_count = (i < DEPTH) ? i + 1 : DEPTH;
      vecs[i].exp_full  = (i >= DEPTH - 1);
      vecs[i].exp_ovf   = (i >= DEPTH);
    end

    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_count", int'(fifo_count), 0);
    check("rst_full", int'(fifo_full), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_dv", int'(tx_dv), 0);
    check("rst_byte", int'(tx_byte), 0);
    reset = 1'b0;

    // single byte with a long level-valid
    base = pulses;
    exp_q.push_back(8'h41);
    @(negedge clk);
    wr_data  = 8'h41;
    wr_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("single_count1", int'(fifo_count), 1);
    repeat (17) @(negedge clk);
    check("single_count0", int'(fifo_count), 0);
    wr_valid = 1'b0;
    wait_drain("single");
    check("single_pulses", pulses - base, 1);
    check("single_hold", int'(tx_byte), 8'h41);

    // burst with full-length frames
    base      = pulses;
    check_gap = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h30 + 8'(i));
      write_byte(8'h30 + 8'(i));
    end
    wait_drain("burst");
    check("burst_pulses", pulses - base, 5);
    check_gap = 1'b0;

    // overflow table with transmitter held busy
    frame_len = 40;
    do_reset();
    base = pulses;
    hold = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i < DEPTH) exp_q.push_back(vecs[i].data);
      write_byte(vecs[i].data);
      check("tbl_count", int'(fifo_count), vecs[i].exp_count);
      check("tbl_full", int'(fifo_full), int'(vecs[i].exp_full));
      check("tbl_ovf", int'(overflow), int'(vecs[i].exp_ovf));
    end
    hold = 1'b0;
    wait_drain("ovf");
    check("ovf_pulses", pulses - base, DEPTH);
    check("ovf_sticky", int'(overflow), 1);

    // write edge coincides with the LOAD pop of a full FIFO
    do_reset();
    base = pulses;
    hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(8'hC0 + 8'(i));
      write_byte(8'hC0 + 8'(i));
    end
    check("sim_full", int'(fifo_full), 1);
    exp_q.push_back(8'h99);
    @(negedge clk);
    wr_data  = 8'h99;
    wr_valid = 1'b1;
    @(negedge clk);
    hold = 1'b0;
    @(negedge clk);
    check("sim_load_dv", int'(tx_dv), 1);
    @(negedge clk);
    check("sim_count", int'(fifo_count), DEPTH);
    check("sim_ovf", int'(overflow), 0);
    repeat (2) @(negedge clk);
    wr_valid = 1'b0;
    wait_drain("sim");
    check("sim_pulses", pulses - base, DEPTH + 1);

    // reset while the first of three bytes is in flight
    frame_len = 1040;
    do_reset();
    base = pulses;
    exp_q.push_back(8'h51);
    write_byte(8'h51);
    write_byte(8'h52);
    write_byte(8'h53);
    check("mid_busy", int'(busy), 1);
    check("mid_count", int'(fifo_count), 2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_count", int'(fifo_count), 0);
    check("mid_rst_dv", int'(tx_dv), 0);
    check("mid_rst_byte", int'(tx_byte), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (frame_len + 200) @(negedge clk);
    check("mid_pulses", pulses - base, 1);
    check("mid_count_after", int'(fifo_count), 0);

    // line feed handling
    base = pulses;
    exp_q.push_back(8'h41);
`ifdef UART_TX_FIFO_CRLF_EN
    exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(8'h0A);
    base = base + exp_q.size();
    write_byte(8'h41);
    write_byte(8'h0A);
    wait_drain("lf");
    check("lf_pulses", pulses, base);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
